// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline.
//   imm_fmt_t : immediate format codes carried on the 3-bit src field
//   INM_W     : width of the raw immediate field (instruction bits [31:7])
package imm_pkg;

   localparam int INM_W = 25;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_fmt_t;

endpackage

// File: rtl/imm_ext_dec.sv
// Combinational immediate decoder: rebuilds the RV immediate from the
// instruction field and sign-extends it to XLEN.
//   inm     in  INM_W  instruction bits [31:7], inm[k] = instr[k+7]
//   src     in  3      format code (imm_fmt_t); codes above IMM_J are illegal
//   inm_ext out XLEN   sign-extended immediate, zero for an illegal code
//   err     out 1      illegal format code
module imm_ext_dec
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [INM_W-1:0] inm,
   input  logic [2:0]       src,
   output logic [XLEN-1:0]  inm_ext,
   output logic             err
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_ext_dec: XLEN must be 32 or 64");
   end

   logic        s;
   logic [31:0] imm32;

   assign s = inm[INM_W-1];

   // Every format carries the sign in bit 31, so one 32-bit result plus a
   // signed widening covers both RV32 and RV64 (U included).
   always_comb begin
      imm32 = '0;
      err   = 1'b0;
      case (src)
         IMM_I:   imm32 = {{20{s}}, inm[24:13]};
         IMM_S:   imm32 = {{20{s}}, inm[24:18], inm[4:0]};
         IMM_B:   imm32 = {{20{s}}, inm[0], inm[23:18], inm[4:1], 1'b0};
         IMM_U:   imm32 = {inm[24:5], 12'b0};
         IMM_J:   imm32 = {{12{s}}, inm[12:5], inm[13], inm[23:14], 1'b0};
         default: err   = 1'b1;
      endcase
   end

   assign inm_ext = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready pipeline around imm_ext_dec. Stage 1 holds the raw
// field and format, stage 2 holds the decoded result. Each stage refills
// when empty or when drained in the same cycle, so the pipe sustains one
// beat per cycle and stalls without losing or duplicating beats.
//   clk, rst  clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready / inm / src          input beat
//   out_valid / out_ready / inm_ext / err    output beat
//   xfer_cnt  wrapping count of output handshakes
module imm_ext_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [INM_W-1:0] inm,
   input  logic [2:0]       src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  inm_ext,
   output logic             err,
   output logic [CNT_W-1:0] xfer_cnt
);

   logic             s1_vld_q, s2_vld_q;
   logic [INM_W-1:0] s1_inm_q;
   logic [2:0]       s1_src_q;
   logic [XLEN-1:0]  s2_ext_q, dec_ext;
   logic             s2_err_q, dec_err;
   logic [CNT_W-1:0] cnt_q;
   logic             s2_load, s1_load;

   // in_ready depends combinationally on out_ready so a full pipe can
   // push and pop in the same cycle.
   assign s2_load  = !s2_vld_q || out_ready;
   assign in_ready = !s1_vld_q || s2_load;
   assign s1_load  = in_valid && in_ready;

   imm_ext_dec #(.XLEN(XLEN)) u_dec (
      .inm     (s1_inm_q),
      .src     (s1_src_q),
      .inm_ext (dec_ext),
      .err     (dec_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_inm_q <= '0;
         s1_src_q <= '0;
      end else if (in_ready) begin
         s1_vld_q <= in_valid;
         if (s1_load) begin
            s1_inm_q <= inm;
            s1_src_q <= src;
         end
      end
   end

   // Data only moves with a real beat, so a bubble leaves the last result
   // in place rather than overwriting it with decode of stale inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld_q <= 1'b0;
         s2_ext_q <= '0;
         s2_err_q <= 1'b0;
      end else if (s2_load) begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            s2_ext_q <= dec_ext;
            s2_err_q <= dec_err;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        cnt_q <= '0;
      else if (s2_vld_q && out_ready) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign out_valid = s2_vld_q;
   assign inm_ext   = s2_ext_q;
   assign err       = s2_err_q;
   assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic [24:0] inm;
   logic [2:0]  src;

   logic        rdy32, ov32, err32;
   logic [31:0] ext32;
   logic [15:0] cnt32;
   logic        rdy64, ov64, err64;
   logic [63:0] ext64;
   logic [15:0] cnt64;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imm_ext_pipe #(.XLEN(32), .CNT_W(16)) u32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
      .inm(inm), .src(src), .out_valid(ov32), .out_ready(out_ready),
      .inm_ext(ext32), .err(err32), .xfer_cnt(cnt32));

   imm_ext_pipe #(.XLEN(64), .CNT_W(16)) u64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
      .inm(inm), .src(src), .out_valid(ov64), .out_ready(out_ready),
      .inm_ext(ext64), .err(err64), .xfer_cnt(cnt64));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One beat with out_ready high: accepted at edge N, invisible after N,
   // visible after N+1.
   task automatic xact(input string tag, input logic [24:0] v, input logic [2:0] f,
                       input logic [31:0] e32, input logic [63:0] e64, input logic e_err);
      @(negedge clk);
      out_ready = 1'b1;
      chk({tag, "_in_ready"}, 64'(rdy32), 64'd1);
      in_valid = 1'b1; inm = v; src = f;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_lat1_valid"}, 64'(ov32), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_valid"}, 64'(ov32), 64'd1);
      chk({tag, "_ext32"}, 64'(ext32), 64'(e32));
      chk({tag, "_err32"}, 64'(err32), 64'(e_err));
      chk({tag, "_ext64"}, ext64, e64);
      chk({tag, "_err64"}, 64'(err64), 64'(e_err));
   endtask

   initial begin
      logic [31:0] held;
      logic        stalled;
      int          k, r, c;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inm = '0; src = '0;
      #12;
      chk("rst_out_valid", 64'(ov32), 64'd0);
      chk("rst_ext", 64'(ext32), 64'd0);
      chk("rst_err", 64'(err32), 64'd0);
      chk("rst_cnt", 64'(cnt32), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(rdy32), 64'd1);

      // Directed formats.
      xact("i_pos", 25'b0000000000010000011000001, 3'b000, 32'h00000001, 64'h1, 1'b0);
      xact("i_neg", 25'b1111111110101111111111111, 3'b000, 32'hFFFFFFFA,
           64'hFFFFFFFF_FFFFFFFA, 1'b0);
      xact("s_fmt", 25'h0000002, 3'b001, 32'h00000002, 64'h2, 1'b0);
      xact("b_fmt", 25'h1FFFFFC, 3'b010, 32'hFFFFF7FC, 64'hFFFFFFFF_FFFFF7FC, 1'b0);
      xact("j_fmt", 25'h0000100, 3'b100, 32'h00008000, 64'h8000, 1'b0);
      xact("u_fmt", {1'b1, 19'h02345, 5'b0}, 3'b011, 32'h82345000,
           64'hFFFFFFFF_82345000, 1'b0);
      xact("illegal", 25'h1ABCDEF, 3'b111, 32'h0, 64'h0, 1'b1);
      xact("post_illegal", 25'h0000002, 3'b001, 32'h00000002, 64'h2, 1'b0);
      @(negedge clk);
      chk("cnt_after_directed", 64'(cnt32), 64'd8);
      chk("cnt64_after_directed", 64'(cnt64), 64'd8);

      // Back-pressure: 5 I beats carrying 1..5, out_ready low for cycles 2-6.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      k = 0; r = 0; stalled = 1'b0; held = '0;
      for (c = 0; c < 40 && r < 5; c++) begin
         @(negedge clk);
         out_ready = !(c >= 2 && c <= 6);
         in_valid  = (k < 5);
         inm       = {12'(k + 1), 13'b0};
         src       = 3'b000;
         #1;
         if (c == 2) chk("bp_in_ready_low", 64'(rdy32), 64'd0);
         if (stalled) begin
            chk("bp_hold_valid", 64'(ov32), 64'd1);
            chk("bp_hold_data", 64'(ext32), 64'(held));
         end
         stalled = ov32 && !out_ready;
         held    = ext32;
         if (in_valid && rdy32) k++;
         if (ov32 && out_ready) begin
            chk("bp_order", 64'(ext32), 64'(r + 1));
            r++;
         end
      end
      chk("bp_all_received", 64'(r), 64'd5);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_no_extra", 64'(ov32), 64'd0);
      chk("bp_cnt", 64'(cnt32), 64'd5);

      // Reset with two beats in flight.
      out_ready = 1'b0;
      in_valid = 1'b1; inm = {12'd7, 13'b0}; src = 3'b000;
      @(negedge clk);
      inm = {12'd8, 13'b0};
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_full_valid", 64'(ov32), 64'd1);
      out_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 64'(ov32), 64'd0);
      chk("mid_rst_cnt", 64'(cnt32), 64'd0);
      rst = 1'b0;
      xact("after_rst", 25'b0000000000010000011000001, 3'b000, 32'h00000001, 64'h1, 1'b0);
      @(negedge clk);
      chk("after_rst_cnt", 64'(cnt32), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised successor to the combinational sign-extension unit. It takes the 25-bit immediate field (instruction bits [31:7]) plus a format selector and produces the sign-extended immediate for RV32 or RV64. The result leaves through a two-stage valid/ready pipeline, so the decode stage can sit between fetch and execute without a combinational path. It adds J-format support as a distinct code, an illegal-format flag, and a transfer counter.

## Interface
- `XLEN`, 32: output width; legal values 32 or 64, anything else is a elaboration error.
- `CNT_W`, 16: width of the transfer counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  the input beat is valid.
- `in_ready`  out  1  the block accepts a beat this cycle.
- `inm`  in  25  instruction bits [31:7]; `inm[k]` = `instr[k+7]`.
- `src`  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 are illegal.
- `out_valid`  out  1  the result beat is valid.
- `out_ready`  in  1  downstream accepts the beat.
- `inm_ext`  out  XLEN  the extended immediate.
- `err`  out  1  the beat carried an illegal `src`.
- `xfer_cnt`  out  CNT_W  count of completed output transfers (`out_valid && out_ready`), wrapping.

## Operation
- Formats; `S` is the sign bit `inm[24]`, replicated to XLEN:
  - I: `{S.., inm[24:13]}`
  - S: `{S.., inm[24:18], inm[4:0]}`
  - B: `{S.., inm[0], inm[23:18], inm[4:1], 1'b0}`
  - U: `{S.., inm[24:5], 12'b0}`; sign-extended above bit 31 when XLEN=64.
  - J: `{S.., inm[12:5], inm[13], inm[23:14], 1'b0}`
  - Illegal `src`: `inm_ext` = 0, `err` = 1. The beat still flows, so it is not dropped.
- Stage 1 registers `inm` and `src` when the input handshake completes (`in_valid && in_ready`).
- The decode is combinational from the stage-1 registers. Its result is registered into stage 2 (the output registers).
- Each stage holds `valid` plus its data. A stage loads when it is empty or when its downstream consumes it in the same cycle.
  - `s2_load = !s2_valid || out_ready`
  - `in_ready = !s1_valid || s2_load`
- Data registers change only on load. `inm_ext` and `err` stay stable while `out_valid && !out_ready`.
- `xfer_cnt` increments by 1 on each output handshake and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values: `out_valid`=0, `inm_ext`=0, `err`=0, `xfer_cnt`=0, both stage valids=0. `in_ready`=1 whenever `rst`=0 and the pipe is empty.
- Latency: a beat accepted at edge N appears at `out_valid` after edge N+1, i.e. 2 cycles.
- Throughput: 1 beat per cycle with `out_ready` held high.
- Back-pressure: with `out_ready`=0 the pipe fills 2 deep, then `in_ready` drops in the same cycle, combinationally from `out_ready` via `s2_load`.
- Simultaneous push and pop on a full pipe: both stages advance and no beat is lost or duplicated.
- Beats leave in acceptance order; no reordering.
- Reset asserted mid-operation: all in-flight beats are discarded immediately and outputs return to their reset values. `xfer_cnt` does not count a handshake in a cycle where `rst` is high.
- Inputs are ignored while `in_ready`=0.

## Structure
- Shared package `imm_pkg`:
  - enum `imm_fmt_t` (IMM_I=3'b000 … IMM_J=3'b100);
  - constant `INM_W`=25.
- Natural sub-module `imm_ext_dec`: purely combinational. Parameter XLEN; inputs `inm` and `src`; outputs `inm_ext` and `err`.
- `imm_ext_pipe` instantiates `imm_ext_dec` between the two stage registers and owns the handshake and the counter.

## Test plan
- I-format, XLEN=32: `inm`=25'b0000000000010000011000001 → 32'h00000001. Then `inm`=25'b1111111110101111111111111 → 32'hFFFFFFFA. Each appears 2 cycles after acceptance; `err`=0.
- S, B and J formats:
  - S `inm`=25'h0000002 → 32'h00000002
  - B `inm`=25'h1FFFFFC → 32'hFFFFF7FC
  - J `inm`=25'h0000100 → 32'h00008000
- U-format at XLEN=64: `inm`=`{1'b1, 19'h02345, 5'b0}` → 64'hFFFFFFFF_82345000.
- Illegal format: `src`=3'b111 with any `inm` → `inm_ext`=0, `err`=1. A legal beat sent next emerges with `err`=0.
- Back-pressure: stream 5 beats with `out_ready` low for cycles 2–6.
  - `in_ready` must go low once 2 beats are held.
  - Output data must stay stable while stalled.
  - All 5 beats must appear in order with no loss or duplicates.
  - `xfer_cnt`=5 at the end.
- Reset mid-stream: assert `rst` with 2 beats in flight → next cycle `out_valid`=0 and `xfer_cnt`=0. After release, a new I beat with result 1 emerges with latency 2.
